// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter in front of a single-cycle data memory.
// Each granted transaction takes one BUSY cycle on the memory port. It is
// followed by one IDLE cycle that carries the ack and the updated read data.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   req/we/addr/wdata{0,1}       requester transaction (held until gnt)
//   gnt{0,1}                     one-cycle grant, high during the BUSY cycle
//   ack{0,1}                     one-cycle completion, high in the following IDLE cycle
//   rdata{0,1}                   per-port read data, held until that port's next read
//   mem_addr/mem_wdata/mem_we    memory request, zero outside BUSY
//   mem_rdata                    memory read data, combinational on mem_addr
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t            state, state_nxt;
    logic              ptr, ptr_nxt;      // port that wins a tie
    logic              win, win_nxt;      // port owning the current transaction
    logic              gnt0_nxt, gnt1_nxt, ack0_nxt, ack1_nxt;
    logic              mem_we_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt;
    logic [DATA_W-1:0] rdata0_nxt, rdata1_nxt;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and next register values. The memory port registers double
    // as the latched transaction, so they hold their values through BUSY.
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        win_nxt       = win;
        gnt0_nxt      = 1'b0;
        gnt1_nxt      = 1'b0;
        ack0_nxt      = 1'b0;
        ack1_nxt      = 1'b0;
        mem_we_nxt    = 1'b0;
        mem_addr_nxt  = '0;
        mem_wdata_nxt = '0;
        rdata0_nxt    = rdata0;
        rdata1_nxt    = rdata1;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    // Lone requester wins; on a tie the pointer decides
                    win_nxt       = (req0 && req1) ? ptr : req1;
                    ptr_nxt       = ~win_nxt;
                    state_nxt     = BUSY;
                    gnt0_nxt      = ~win_nxt;
                    gnt1_nxt      = win_nxt;
                    mem_we_nxt    = win_nxt ? we1    : we0;
                    mem_addr_nxt  = win_nxt ? addr1  : addr0;
                    mem_wdata_nxt = win_nxt ? wdata1 : wdata0;
                end
            end
            BUSY: begin
                state_nxt = IDLE;
                ack0_nxt  = ~win;
                ack1_nxt  = win;
                if (!mem_we) begin
                    if (win) rdata1_nxt = mem_rdata;
                    else     rdata0_nxt = mem_rdata;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output and bookkeeping registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= 1'b0;
            win       <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            ptr       <= ptr_nxt;
            win       <= win_nxt;
            gnt0      <= gnt0_nxt;
            gnt1      <= gnt1_nxt;
            ack0      <= ack0_nxt;
            ack1      <= ack1_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            rdata0    <= rdata0_nxt;
            rdata1    <= rdata1_nxt;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a transaction-level
// reference model and a small behavioural data memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic        gnt0, gnt1, ack0, ack1, mem_we;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int failures = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural 16-word data memory
    logic [31:0] mem [16];
    assign mem_rdata = mem[mem_addr[3:0]];
    always @(posedge clk) if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one open transaction at a time. A new transaction may
    // only start once the previous one has been completed for a cycle.
    logic        m_open;
    logic        m_next;            // port that wins a tie
    logic        m_port;
    logic        m_we;
    logic [31:0] m_addr, m_wdata;
    logic [1:0]  e_gnt, e_ack;
    logic [31:0] e_rdata [2];
    logic        e_we;
    logic [31:0] e_addr, e_wdata;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_open = 1'b0; m_next = 1'b0; m_port = 1'b0;
            e_gnt = 2'b00; e_ack = 2'b00;
            e_rdata[0] = '0; e_rdata[1] = '0;
            e_we = 1'b0; e_addr = '0; e_wdata = '0;
        end else if (m_open) begin
            // Transaction completes: ack its owner, deliver read data
            m_open = 1'b0;
            e_gnt = 2'b00;
            e_ack = (m_port == 1'b1) ? 2'b10 : 2'b01;
            if (!m_we) e_rdata[m_port] = mem[m_addr[3:0]];
            e_we = 1'b0; e_addr = '0; e_wdata = '0;
        end else begin
            e_ack = 2'b00;
            if (req0 || req1) begin
                if (req0 && req1) m_port = m_next;
                else              m_port = req1;
                m_next  = !m_port;
                m_open  = 1'b1;
                m_we    = m_port ? we1 : we0;
                m_addr  = m_port ? addr1 : addr0;
                m_wdata = m_port ? wdata1 : wdata0;
                e_gnt   = (m_port == 1'b1) ? 2'b10 : 2'b01;
                e_we = m_we; e_addr = m_addr; e_wdata = m_wdata;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            check("gnt0", gnt0, e_gnt[0]);
            check("gnt1", gnt1, e_gnt[1]);
            check("ack0", ack0, e_ack[0]);
            check("ack1", ack1, e_ack[1]);
            check("rdata0", rdata0, e_rdata[0]);
            check("rdata1", rdata1, e_rdata[1]);
            check("mem_we", mem_we, e_we);
            check("mem_addr", mem_addr, e_addr);
            check("mem_wdata", mem_wdata, e_wdata);
            check("gnt_both", gnt0 & gnt1, 1'b0);
            check("ack_both", ack0 & ack1, 1'b0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
    endtask

    logic [3:0]  seq_exp [4];
    logic [31:0] rd_exp [3];
    int          order [8];

    initial begin
        int n, g0, g1, cyc, k, a, last;
        logic [3:0] code;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33;
        seq_exp[0] = 4'b1000; seq_exp[1] = 4'b0100; seq_exp[2] = 4'b0010; seq_exp[3] = 4'b0001;
        rd_exp[0] = 32'h11; rd_exp[1] = 32'h22; rd_exp[2] = 32'h33;

        do_reset();
        check("reset_rdata0", rdata0, 32'h0);
        check("reset_mem_we", mem_we, 1'b0);

        // Port 0 writes 7 to word 4
        @(negedge clk); req0 = 1'b1; we0 = 1'b1; addr0 = 32'd4; wdata0 = 32'h7;
        @(negedge clk);
        check("wr_gnt0", gnt0, 1'b1);
        check("wr_mem_we", mem_we, 1'b1);
        check("wr_mem_addr", mem_addr, 32'd4);
        req0 = 1'b0;
        @(negedge clk);
        check("wr_ack0", ack0, 1'b1);
        check("wr_rdata0", rdata0, 32'h0);
        // Port 1 reads word 4 back
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd4;
        @(negedge clk);
        check("rd_gnt1", gnt1, 1'b1);
        check("rd_mem_we", mem_we, 1'b0);
        req1 = 1'b0;
        @(negedge clk);
        check("rd_ack1", ack1, 1'b1);
        check("rd_rdata1", rdata1, 32'h7);
        check("rd_rdata0_kept", rdata0, 32'h0);

        // Simultaneous requests right after reset: gnt0, ack0, gnt1, ack1
        do_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd4;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd4;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            code = {gnt0, ack0, gnt1, ack1};
            check("tie_sequence", code, seq_exp[i]);
            if (gnt0) req0 = 1'b0;
            if (gnt1) req1 = 1'b0;
        end

        // Both held for 8 transactions: strict alternation
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd8; wdata0 = 32'h100;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd8;
        n = 0; g0 = 0; g1 = 0; cyc = 0;
        while (n < 8 && cyc < 40) begin
            @(negedge clk); cyc++;
            check("gnt_ack_overlap0", gnt0 & ack0, 1'b0);
            check("gnt_ack_overlap1", gnt1 & ack1, 1'b0);
            if (gnt0 && n < 8) begin
                order[n] = 0; n++; g0++; wdata0 = wdata0 + 32'd1;
                if (g0 == 4) req0 = 1'b0;
            end
            if (gnt1 && n < 8) begin
                order[n] = 1; n++; g1++;
                if (g1 == 4) req1 = 1'b0;
            end
        end
        check("rr_grant_count", n, 8);
        for (int i = 0; i < 8; i++) check("rr_order", order[i], i % 2);
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(negedge clk);

        // Port 0 alone: back-to-back reads of words 0,1,2
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd0;
        k = 0; a = 0; cyc = 0; last = 0;
        while (a < 3 && cyc < 30) begin
            @(negedge clk); cyc++;
            if (gnt0) begin
                if (k > 0) check("gnt0_spacing", cyc - last, 2);
                last = cyc; k++;
                if (k < 3) addr0 = 32'(k);
                else       req0 = 1'b0;
            end
            if (ack0) begin
                check("seq_rdata0", rdata0, rd_exp[a]);
                a++;
            end
        end
        check("seq_ack_count", a, 3);
        req0 = 1'b0;
        @(negedge clk);

        // Reset in the middle of a write: memory port drops at once, no ack
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd9; wdata0 = 32'hAB;
        @(negedge clk);
        check("abort_gnt0", gnt0, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("abort_mem_we", mem_we, 1'b0);
        check("abort_gnt0_low", gnt0, 1'b0);
        check("abort_ack0", ack0, 1'b0);
        req0 = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_no_ack", ack0, 1'b0);
        #2 rst = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd9;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd9;
        @(negedge clk);
        check("post_reset_gnt0", gnt0, 1'b1);
        check("post_reset_gnt1", gnt1, 1'b0);
        req0 = 1'b0;
        @(negedge clk);
        check("post_reset_ack0", ack0, 1'b1);
        check("post_reset_rdata0", rdata0, 32'h0);
        @(negedge clk);
        check("post_reset_gnt1_next", gnt1, 1'b1);
        req1 = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_write", mem[9], 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the address width of both requester ports and the memory port.
REQ-002 Parameter DATA_W, default 32, SHALL set the data width of both requester ports and the memory port.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 rst  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 req0/req1  in  1  SHALL be the per-requester transaction request, held until the matching gnt is seen.
REQ-006 we0/we1  in  1  SHALL select write (1) or read (0), stable while req is high.
REQ-007 addr0/addr1  in  ADDR_W  SHALL be the word address, stable while req is high.
REQ-008 wdata0/wdata1  in  DATA_W  SHALL be the write data, stable while req is high.
REQ-009 gnt0/gnt1  out  1  SHALL be a one-cycle grant pulse.
REQ-010 ack0/ack1  out  1  SHALL be a one-cycle completion pulse for reads and writes.
REQ-011 rdata0/rdata1  out  DATA_W  SHALL be registered read data, held until that port's next read completes.
REQ-012 mem_addr  out  ADDR_W  SHALL drive the data memory address.
REQ-013 mem_wdata  out  DATA_W  SHALL drive the data memory write data.
REQ-014 mem_we  out  1  SHALL drive the data memory write enable.
REQ-015 mem_rdata  in  DATA_W  SHALL be the data memory read data, combinationally valid for mem_addr.

Function
REQ-016 FSM SHALL have two states, IDLE and BUSY.
REQ-017 In IDLE at a rising edge, if any req is high, the FSM SHALL choose a winner, latch its we/addr/wdata and enter BUSY; otherwise it SHALL remain in IDLE.
REQ-018 Winner selection: if one req is high, that port wins; if both are high, the port named by the priority pointer wins.
REQ-019 After each grant, the pointer SHALL point to the other port (round-robin); the pointer SHALL not change when no grant occurs.
REQ-020 gnt of the winner SHALL be high for exactly the BUSY cycle; both gnt SHALL be low in IDLE.
REQ-021 In BUSY, mem_addr/mem_wdata/mem_we SHALL equal the latched values; in IDLE, mem_we SHALL be 0 and mem_addr/mem_wdata SHALL be 0.
REQ-022 At the edge ending BUSY, a read SHALL capture mem_rdata into the winner's rdata; the FSM SHALL return to IDLE.
REQ-023 The winner's ack SHALL be high for the one IDLE cycle following BUSY.
REQ-024 Latency: req sampled at edge E0 -> gnt in cycle E0..E1 -> ack (and rdata) in cycle E1..E2; sustained throughput is one transaction per 2 cycles.
REQ-025 req SHALL only be sampled in IDLE; a req withdrawn before grant SHALL have no effect.
REQ-026 A write SHALL never alter rdata.
REQ-027 Both gnt high, or both ack high, in the same cycle SHALL never occur.
REQ-028 With both reqs held continuously, grants SHALL alternate, so each requester waits at most one foreign transaction.

Reset
REQ-029 rst SHALL asynchronously force state=IDLE, pointer=port 0, gnt0/gnt1/ack0/ack1=0, mem_we=0, mem_addr/mem_wdata=0, rdata0/rdata1=0.
REQ-030 rst during BUSY SHALL abort the transaction: no ack, no rdata update, mem_we low immediately; the requester reissues.

Verification
REQ-031 After reset, req0 write addr=4 wdata=0x00000007 -> gnt0 one cycle later with mem_we=1, mem_addr=4; ack0 the cycle after; rdata0 stays 0.
REQ-032 Then req1 read addr=4 -> gnt1, mem_we=0; ack1 with rdata1=0x00000007; rdata0 unchanged.
REQ-033 req0 and req1 raised together right after reset -> port 0 served first, then port 1, with the sequence gnt0, ack0, gnt1, ack1 at 1-cycle spacing.
REQ-034 req0 and req1 held high for 8 transactions -> grant order 0,1,0,1,0,1,0,1; gnt never overlaps ack of the same port.
REQ-035 Only req0 held with 3 back-to-back reads at addr 0,1,2 -> gnt0 every 2 cycles; rdata0 equals memory words 0,1,2 at the successive ack0.
REQ-036 Assert rst mid-BUSY on a write -> mem_we falls without a clock edge; no ack; after release, pointer=0 and a simultaneous request pair is granted to port 0.
